// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: PC constants, NOP encoding and IF/ID slot layout.
package fetch_stage_pkg;

    localparam logic [31:0] PC_RESET     = 32'h0040_0000;
    localparam logic [31:0] PC_INCREMENT = 32'h0000_0004;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

    // IF/ID field widths, shared with the decode stage
    localparam int unsigned IFID_INSTR_WIDTH = 32;
    localparam int unsigned IFID_PC_WIDTH    = 32;

    typedef struct packed {
        logic [IFID_INSTR_WIDTH-1:0] instr;
        logic [IFID_PC_WIDTH-1:0]    pc;
        logic [IFID_PC_WIDTH-1:0]    pcPlus4;
        logic                        valid;
    } ifidSlot_t;

    // Word-align an address by clearing its two low bits
    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_select.sv
// Next-PC priority mux: priming, redirect (word-aligned), stall, sequential.
module fetch_pc_select
    import fetch_stage_pkg::*;
(
    input  logic        started,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    input  logic        stall,
    input  logic [31:0] pc,
    output logic [31:0] nextPc,
    output logic        misaligned
);

    // Priority: priming beats redirect beats stall beats sequential fetch
    always_comb begin
        nextPc = pc + PC_INCREMENT;
        if (!started) begin
            nextPc = PC_RESET;
        end else if (redirect) begin
            nextPc = alignWord(redirectTarget);
        end else if (stall) begin
            nextPc = pc;
        end
    end

    // Only a redirect that is actually taken can report a misaligned target
    always_comb begin
        misaligned = started && redirect && (redirectTarget[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous ROM and fills IF/ID.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_target_in,
    output logic [31:0] imem_addr_out,
    input  logic [31:0] imem_data_in,
    output logic [31:0] ifid_instr_out,
    output logic [31:0] ifid_pc_out,
    output logic [31:0] ifid_pc_plus4_out,
    output logic        ifid_valid_out,
    output logic        misaligned_out,
    output logic [31:0] fetch_count_out
);

    // pc is the address of the word currently arriving on imem_data_in
    logic [31:0] pc;
    logic        started;
    logic [31:0] nextPc;
    logic        misalignedNext;
    ifidSlot_t   ifid;
    logic        misaligned;
    logic [31:0] fetchCount;

    fetch_pc_select pcSelect (
        .started        (started),
        .redirect       (redirect_in),
        .redirectTarget (redirect_target_in),
        .stall          (stall_in),
        .pc             (pc),
        .nextPc         (nextPc),
        .misaligned     (misalignedNext)
    );

    // ROM address is the next PC so the word lands on the edge that latches it into pc
    assign imem_addr_out = nextPc;

    // PC and priming flag; the first edge after reset only primes the ROM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc      <= PC_RESET;
            started <= 1'b0;
        end else begin
            pc      <= nextPc;
            started <= 1'b1;
        end
    end

    // IF/ID slot and fetch counter: flush on redirect, hold on stall, else load
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ifid       <= '{instr: NOP_WORD, pc: '0, pcPlus4: '0, valid: 1'b0};
            fetchCount <= '0;
        end else if (!started || redirect_in) begin
            ifid <= '{instr: NOP_WORD, pc: '0, pcPlus4: '0, valid: 1'b0};
        end else if (!stall_in) begin
            ifid       <= '{instr: imem_data_in, pc: pc, pcPlus4: pc + PC_INCREMENT,
                            valid: 1'b1};
            fetchCount <= fetchCount + 32'd1;
        end
    end

    // One-cycle pulse after a taken redirect to an unaligned target
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            misaligned <= 1'b0;
        end else begin
            misaligned <= misalignedNext;
        end
    end

    assign ifid_instr_out    = ifid.instr;
    assign ifid_pc_out       = ifid.pc;
    assign ifid_pc_plus4_out = ifid.pcPlus4;
    assign ifid_valid_out    = ifid.valid;
    assign misaligned_out    = misaligned;
    assign fetch_count_out   = fetchCount;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan scenarios plus random stall/redirect.
module tb_fetch_stage;

    localparam logic [31:0] PcReset = 32'h0040_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        redirect_in;
    logic [31:0] redirect_target_in;
    logic [31:0] imem_addr_out;
    logic [31:0] imem_data_in;
    logic [31:0] ifid_instr_out;
    logic [31:0] ifid_pc_out;
    logic [31:0] ifid_pc_plus4_out;
    logic        ifid_valid_out;
    logic        misaligned_out;
    logic [31:0] fetch_count_out;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: address of the word in flight plus the expected IF/ID view
    logic [31:0] mPc;
    logic        mStarted;
    logic [31:0] eInstr, ePc, ePc4, eCount;
    logic        eValid, eMis;

    always #5 clock = ~clock;

    fetch_stage dut (
        .clock              (clock),
        .reset              (reset),
        .stall_in           (stall_in),
        .redirect_in        (redirect_in),
        .redirect_target_in (redirect_target_in),
        .imem_addr_out      (imem_addr_out),
        .imem_data_in       (imem_data_in),
        .ifid_instr_out     (ifid_instr_out),
        .ifid_pc_out        (ifid_pc_out),
        .ifid_pc_plus4_out  (ifid_pc_plus4_out),
        .ifid_valid_out     (ifid_valid_out),
        .misaligned_out     (misaligned_out),
        .fetch_count_out    (fetch_count_out)
    );

    // ROM contents as a pure function of address
    function automatic logic [31:0] romWord(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h1111_1111;
        if (a == 32'h0040_0004) return 32'h2222_2222;
        return {a[15:0], ~a[31:16]} ^ 32'h5a5a_0000;
    endfunction

    // Synchronous ROM, one-cycle read latency
    always @(posedge clock) imem_data_in <= romWord(imem_addr_out);

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkEq({tag, ".instr"}, ifid_instr_out, eInstr);
        checkEq({tag, ".pc"}, ifid_pc_out, ePc);
        checkEq({tag, ".pc4"}, ifid_pc_plus4_out, ePc4);
        checkEq({tag, ".valid"}, {31'd0, ifid_valid_out}, {31'd0, eValid});
        checkEq({tag, ".mis"}, {31'd0, misaligned_out}, {31'd0, eMis});
        checkEq({tag, ".count"}, fetch_count_out, eCount);
    endtask

    task automatic modelReset();
        mPc = PcReset; mStarted = 1'b0;
        eInstr = 32'd0; ePc = 32'd0; ePc4 = 32'd0; eValid = 1'b0; eMis = 1'b0; eCount = 32'd0;
    endtask

    // Apply one cycle of inputs, check the ROM address, clock, then check IF/ID
    task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt);
        logic [31:0] ea;
        stall_in = st; redirect_in = rd; redirect_target_in = tgt;
        if (!mStarted)  ea = PcReset;
        else if (rd)    ea = tgt & 32'hffff_fffc;
        else if (st)    ea = mPc;
        else            ea = mPc + 32'd4;
        #1;
        checkEq("imem_addr", imem_addr_out, ea);
        @(posedge clock);
        #1;
        eMis = 1'b0;
        if (!mStarted || rd) begin
            eInstr = 32'd0; ePc = 32'd0; ePc4 = 32'd0; eValid = 1'b0;
            if (mStarted) eMis = (tgt % 4) != 0;
        end else if (!st) begin
            eInstr = romWord(mPc); ePc = mPc; ePc4 = mPc + 32'd4; eValid = 1'b1;
            eCount = eCount + 32'd1;
        end
        mPc = ea; mStarted = 1'b1;
        checkAll("cycle");
    endtask

    // Reset pulse entirely between two clock edges
    task automatic asyncPulse();
        reset = 1'b1;
        #1;
        modelReset();
        checkAll("async_reset");
        checkEq("async_reset.addr", imem_addr_out, PcReset);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int guard;
        logic [31:0] tgt;
        reset = 1'b1; stall_in = 1'b0; redirect_in = 1'b0; redirect_target_in = 32'd0;
        modelReset();
        #12;
        checkAll("reset");
        checkEq("reset.addr", imem_addr_out, PcReset);
        @(posedge clock); #1;
        reset = 1'b0;

        // Priming and first fetch
        cycle(1'b0, 1'b0, 32'd0);
        checkEq("prime.valid", {31'd0, ifid_valid_out}, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        checkEq("first.instr", ifid_instr_out, 32'h1111_1111);
        checkEq("first.pc", ifid_pc_out, 32'h0040_0000);
        checkEq("first.pc4", ifid_pc_plus4_out, 32'h0040_0004);
        checkEq("first.count", fetch_count_out, 32'd1);
        checkEq("second.addr", imem_addr_out, 32'h0040_0008);

        // Redirect while 0x00400008 sits in IF/ID
        cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        checkEq("pre_redirect.pc", ifid_pc_out, 32'h0040_0008);
        cycle(1'b0, 1'b1, 32'h0040_0100);
        checkEq("bubble.valid", {31'd0, ifid_valid_out}, 32'd0);
        checkEq("bubble.instr", ifid_instr_out, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        checkEq("target.pc", ifid_pc_out, 32'h0040_0100);
        checkEq("target.valid", {31'd0, ifid_valid_out}, 32'd1);

        // Three-cycle stall, then resume
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0);
        checkEq("stall_hold.pc", ifid_pc_out, 32'h0040_0100);
        cycle(1'b0, 1'b0, 32'd0);
        checkEq("resume.pc", ifid_pc_out, 32'h0040_0104);
        cycle(1'b0, 1'b0, 32'd0);

        // Redirect and stall together: redirect wins
        cycle(1'b1, 1'b1, 32'h0040_0200);
        checkEq("red_stall.valid", {31'd0, ifid_valid_out}, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        checkEq("red_stall.pc", ifid_pc_out, 32'h0040_0200);

        // Misaligned redirect
        cycle(1'b0, 1'b1, 32'h0040_0102);
        checkEq("misaligned.pulse", {31'd0, misaligned_out}, 32'd1);
        cycle(1'b0, 1'b0, 32'd0);
        checkEq("misaligned.clear", {31'd0, misaligned_out}, 32'd0);
        checkEq("misaligned.pc", ifid_pc_out, 32'h0040_0100);

        // Run to pc 0x00400040, then async reset between edges
        cycle(1'b0, 1'b1, 32'h0040_0000);
        guard = 0;
        while (mPc != 32'h0040_0040 && guard < 64) begin
            cycle(1'b0, 1'b0, 32'd0);
            guard++;
        end
        checkEq("reach_0x40", mPc, 32'h0040_0040);
        asyncPulse();
        cycle(1'b1, 1'b0, 32'd0);  // stall ignored while priming
        cycle(1'b0, 1'b0, 32'd0);
        checkEq("restart.pc", ifid_pc_out, 32'h0040_0000);

        // Wrap-around of sequential fetch
        cycle(1'b0, 1'b1, 32'hffff_fff8);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0);

        // Random stall/redirect/reset traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                asyncPulse();
            end else begin
                case ($urandom_range(0, 3))
                    0:       tgt = $urandom;
                    1:       tgt = 32'hffff_fff0 + $urandom_range(0, 15);
                    default: tgt = 32'h0040_0000 + $urandom_range(0, 1023);
                endcase
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, tgt);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
